// File: rtl/imem_loader.sv
// Instruction-memory loader: accepts 32-bit words from a valid/ready source and
// writes them little-endian, one byte per cycle, into a byte-wide memory port.
module imem_loader #(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  input  logic              in_valid,
  input  logic [31:0]       in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int SUM_W = ADDR_W + CNT_W + 2;

  typedef enum logic [1:0] {IDLE, WAIT_WORD, WRITE, DONE} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] ptr;
  logic [CNT_W-1:0]  count;
  logic [31:0]       word;
  logic [1:0]        byte_idx;
  logic [1:0]        next_idx;
  logic [SUM_W-1:0]  end_addr;
  logic [SUM_W-1:0]  limit;
  logic              start_ok;

  // Range check is done wide enough that base + 4*count can never wrap.
  assign end_addr = SUM_W'(base_addr) + (SUM_W'(word_count) << 2);
  assign limit    = SUM_W'(1) << ADDR_W;
  assign start_ok = (base_addr[1:0] == 2'b00) && (end_addr <= limit);
  assign next_idx = byte_idx + 2'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    mem_we     = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start && start_ok)
          state_next = (word_count == '0) ? DONE : WAIT_WORD;
      end
      WAIT_WORD: begin
        in_ready = 1'b1;
        if (in_valid) state_next = WRITE;
      end
      WRITE: begin
        mem_we = 1'b1;
        if (byte_idx == 2'd3)
          state_next = (count == CNT_W'(1)) ? DONE : WAIT_WORD;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Write address/data are registered so they hold their last value between bursts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
      count     <= '0;
      word      <= '0;
      byte_idx  <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      err       <= 1'b0;
    end else begin
      err <= (state == IDLE) && start && !start_ok;
      case (state)
        IDLE: begin
          if (start && start_ok) begin
            ptr   <= base_addr;
            count <= word_count;
          end
        end
        WAIT_WORD: begin
          if (in_valid) begin
            word      <= in_data;
            byte_idx  <= 2'd0;
            mem_addr  <= ptr;
            mem_wdata <= in_data[7:0];
          end
        end
        WRITE: begin
          if (byte_idx == 2'd3) begin
            ptr   <= ptr + ADDR_W'(4);
            count <= count - CNT_W'(1);
          end else begin
            byte_idx  <= next_idx;
            mem_addr  <= ptr + ADDR_W'(next_idx);
            mem_wdata <= word[{next_idx, 3'b000} +: 8];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed and random sessions compared
// against a byte-write list built from base address, word count and data words.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] base_addr;
  logic [15:0] word_count;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        busy;
  logic        done;
  logic        err;

  int errors = 0;
  int checks = 0;

  logic [23:0] obs_q[$];
  logic [23:0] exp_q[$];
  int          done_seen = 0;
  int          err_seen  = 0;

  imem_loader #(.ADDR_W(16), .CNT_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Records every byte write and every done/err pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_we === 1'b1) obs_q.push_back({mem_addr, mem_wdata});
    if (done === 1'b1) done_seen++;
    if (err === 1'b1) err_seen++;
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_writes(input string tag, input int from);
    int n;
    n = obs_q.size() - from;
    check_output({tag, " write count"}, 32'(n), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < n; i++)
      check_output({tag, " write"}, {8'h0, obs_q[from + i]}, {8'h0, exp_q[i]});
  endtask

  task automatic apply_stimulus(input string tag, input logic [15:0] base, input logic [15:0] count,
                                input int gap, input bit busy_start,
                                input bit use_first, input logic [31:0] first_word);
    logic [31:0] words[$];
    logic [31:0] w;
    logic [15:0] a;
    int from, d0, e0, n;
    bit ok;
    from = obs_q.size();
    d0 = done_seen;
    e0 = err_seen;
    exp_q.delete();
    n  = int'(count);
    ok = (base[1:0] == 2'b00) && (int'(base) + 4 * n <= 65536);
    for (int i = 0; i < n; i++) begin
      w = (use_first && i == 0) ? first_word : $urandom;
      words.push_back(w);
      if (ok)
        for (int b = 0; b < 4; b++) begin
          a = base + 16'(4 * i + b);
          exp_q.push_back({a, w[8*b +: 8]});
        end
    end

    @(negedge clk);
    start = 1'b1; base_addr = base; word_count = count;
    @(negedge clk);
    start = 1'b0; base_addr = 16'($urandom); word_count = 16'($urandom);

    if (!ok) begin
      check_output({tag, " err pulse"}, err, 1'b1);
      check_output({tag, " busy on reject"}, busy, 1'b0);
      @(negedge clk);
      check_output({tag, " err one cycle"}, err, 1'b0);
    end else if (n == 0) begin
      check_output({tag, " busy empty"}, busy, 1'b1);
      check_output({tag, " done empty"}, done, 1'b1);
      @(negedge clk);
      check_output({tag, " busy after"}, busy, 1'b0);
    end else begin
      check_output({tag, " ready first"}, in_ready, 1'b1);
      for (int i = 0; i < n; i++) begin
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          check_output({tag, " ready stalled"}, in_ready, 1'b1);
        end
        in_valid = 1'b1;
        in_data  = words[i];
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = $urandom;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          check_output({tag, " ready in write"}, in_ready, 1'b0);
          check_output({tag, " we in write"}, mem_we, 1'b1);
          in_valid = (k < 3);
          if (busy_start && i == 0 && k == 1) begin
            start = 1'b1; base_addr = 16'h0400; word_count = 16'h0007;
          end else begin
            start = 1'b0;
          end
        end
        in_valid = 1'b0;
        @(negedge clk);
        if (i == n - 1) begin
          check_output({tag, " done"}, done, 1'b1);
          check_output({tag, " busy in done"}, busy, 1'b1);
        end else begin
          check_output({tag, " ready next"}, in_ready, 1'b1);
        end
      end
      @(negedge clk);
      check_output({tag, " busy end"}, busy, 1'b0);
      check_output({tag, " we idle"}, mem_we, 1'b0);
      check_output({tag, " addr hold"}, mem_addr, exp_q[exp_q.size() - 1][23:8]);
      check_output({tag, " data hold"}, mem_wdata, exp_q[exp_q.size() - 1][7:0]);
    end
    check_output({tag, " done count"}, 32'(done_seen - d0), (ok ? 32'd1 : 32'd0));
    check_output({tag, " err count"}, 32'(err_seen - e0), (ok ? 32'd0 : 32'd1));
    check_writes(tag, from);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_output({tag, " in_ready"}, in_ready, 1'b0);
    check_output({tag, " mem_we"}, mem_we, 1'b0);
    check_output({tag, " busy"}, busy, 1'b0);
    check_output({tag, " done"}, done, 1'b0);
    check_output({tag, " err"}, err, 1'b0);
    check_output({tag, " mem_addr"}, mem_addr, 16'h0);
    check_output({tag, " mem_wdata"}, mem_wdata, 8'h0);
  endtask

  initial begin
    int from;
    logic [15:0] rb;
    rst_n = 1'b0; start = 1'b0; base_addr = '0; word_count = '0;
    in_valid = 1'b0; in_data = '0;
    #1;
    check_idle_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    apply_stimulus("single", 16'h0000, 16'd1, 0, 1'b0, 1'b1, 32'h015A04B3);
    apply_stimulus("stall3", 16'h0024, 16'd3, 7, 1'b0, 1'b0, 32'h0);
    apply_stimulus("misalign", 16'h0002, 16'd1, 0, 1'b0, 1'b0, 32'h0);
    apply_stimulus("overflow", 16'hFFFC, 16'd2, 0, 1'b0, 1'b0, 32'h0);
    apply_stimulus("top", 16'hFFFC, 16'd1, 1, 1'b0, 1'b0, 32'h0);
    apply_stimulus("empty", 16'h0100, 16'd0, 0, 1'b0, 1'b0, 32'h0);

    // Reset after the second byte has been committed aborts the session.
    from = obs_q.size();
    exp_q.delete();
    exp_q.push_back({16'h0030, 8'h93});
    exp_q.push_back({16'h0031, 8'h80});
    @(negedge clk);
    start = 1'b1; base_addr = 16'h0030; word_count = 16'd1;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; in_data = 32'h00108093;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_idle_outputs("mid reset");
    @(negedge clk);
    check_idle_outputs("held reset");
    check_writes("aborted", from);
    rst_n = 1'b1; start = 1'b1; base_addr = 16'h0040; word_count = 16'd0;
    @(negedge clk);
    start = 1'b0;
    check_output("first edge accept", busy, 1'b1);
    @(negedge clk);
    apply_stimulus("after reset", 16'h0030, 16'd1, 0, 1'b0, 1'b1, 32'h00108093);

    apply_stimulus("busy start", 16'h0200, 16'd2, 1, 1'b1, 1'b0, 32'h0);

    for (int r = 0; r < 6; r++) begin
      rb = 16'($urandom);
      if ($urandom_range(0, 3) != 0) rb[1:0] = 2'b00;
      if (r == 5) rb = 16'hFFF4;
      apply_stimulus("random", rb, 16'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
                     1'b0, 1'b0, 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL provide parameter ADDR_W, default 16, the byte-address width of the instruction memory write port (64 KiB).
REQ-002 SHALL provide parameter CNT_W, default 16, the width of the word-count input.
REQ-003 SHALL have one clock and an asynchronous, active-low reset.
REQ-004 clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 start  in  1  one-cycle request to begin a load session; sampled only in IDLE.
REQ-007 base_addr  in  ADDR_W  first byte address of the session; sampled with start.
REQ-008 word_count  in  CNT_W  number of 32-bit words to load; sampled with start.
REQ-009 in_valid  in  1  the source presents a word on in_data.
REQ-010 in_data  in  32  instruction word to store.
REQ-011 in_ready  out  1  the loader accepts in_data this cycle.
REQ-012 mem_we  out  1  byte write strobe to the instruction memory.
REQ-013 mem_addr  out  ADDR_W  byte address for the write.
REQ-014 mem_wdata  out  8  byte to write.
REQ-015 busy  out  1  high from session acceptance until done or err; the core holds its PC while busy is high.
REQ-016 done  out  1  one-cycle pulse when a session completes.
REQ-017 err  out  1  one-cycle pulse when a start is rejected.

Function
REQ-018 SHALL implement states IDLE, WAIT_WORD, WRITE, DONE.
REQ-019 IDLE with start=1: reject when base_addr[1:0]!=0 or base_addr+4*word_count > 2^ADDR_W (computed at ADDR_W+CNT_W+2 bits); a rejection pulses err the next cycle and stays in IDLE.
REQ-020 IDLE with start=1, accepted, word_count=0: go to DONE; no writes occur.
REQ-021 IDLE with start=1, accepted, word_count>0: latch the address pointer and remaining count, then go to WAIT_WORD.
REQ-022 in_ready SHALL be high only in WAIT_WORD; a word is accepted in the cycle where in_valid and in_ready are both high.
REQ-023 Accepting a word SHALL latch it and enter WRITE with byte index 0.
REQ-024 WRITE SHALL assert mem_we for exactly 4 consecutive cycles, writing little-endian: in_data[7:0] to ptr, [15:8] to ptr+1, [23:16] to ptr+2, [31:24] to ptr+3.
REQ-025 The first byte write SHALL occur in the cycle after acceptance, so a word costs at least 5 cycles.
REQ-026 After byte 3: advance ptr by 4, decrement the remaining count, then go to DONE if the count reaches 0, otherwise to WAIT_WORD.
REQ-027 DONE SHALL last one cycle, assert done for that cycle, and return to IDLE.
REQ-028 busy SHALL be high in WAIT_WORD, WRITE and DONE, and low in IDLE.
REQ-029 start SHALL be ignored while busy.
REQ-030 in_valid and in_data SHALL be ignored outside WAIT_WORD.
REQ-031 When mem_we=0, mem_addr and mem_wdata SHALL hold their last values.
REQ-032 in_valid low in WAIT_WORD SHALL stall the session indefinitely with no timeout.
REQ-033 No address wrap is possible once a session is accepted, because REQ-019 rejects any overflowing range.

Reset
REQ-034 rst_n=0 SHALL immediately force state IDLE and drive in_ready, mem_we, busy, done and err to 0.
REQ-035 rst_n=0 SHALL immediately force mem_addr, mem_wdata, the pointer, the count and the latched word to 0.
REQ-036 A reset asserted mid-WRITE SHALL abort the session; bytes already written stay in memory, and no further write occurs.
REQ-037 After rst_n deasserts, the first possible session acceptance SHALL be on the first rising clock edge.

Verification
REQ-038 start, base=0x0000, count=1, word 0x015A04B3 -> writes B3@0x0, 04@0x1, 5A@0x2, 01@0x3 on consecutive cycles; done one cycle later; busy then falls.
REQ-039 base=0x0024, count=3, in_valid withheld 7 cycles between words -> 12 byte writes at 0x24..0x2F in order; in_ready high only while waiting; exactly one done.
REQ-040 base=0x0002, count=1 -> err pulse, busy stays 0, no mem_we. Separately, base=0xFFFC, count=2 -> err, no writes; base=0xFFFC, count=1 -> accepted, last write at 0xFFFF.
REQ-041 count=0 at base 0x0100 -> busy high 1 cycle, done pulse, zero writes.
REQ-042 rst_n pulsed low after byte 1 of word 0x00108093 at base 0x30 -> only 93@0x30 and 80@0x31 written, outputs 0 during reset. A new session after release completes normally.
REQ-043 start pulsed while busy with different base/count -> ignored; the original session finishes unchanged.
